// File: rtl/phy_power_sequencer_pkg.sv
// Shared state encodings and timer sizing for the PHY power sequencer.
// G_DOWN exists only when PHY_SEQ_POWER_DOWN_EN is defined.
package phy_power_sequencer_pkg;

`ifdef PHY_SEQ_POWER_DOWN_EN
  typedef enum logic [1:0] {
    G_OFF, G_VDDH, G_ON, G_DOWN
  } g_state_e;
`else
  typedef enum logic [1:0] {
    G_OFF, G_VDDH, G_ON
  } g_state_e;
`endif

  typedef enum logic [1:0] {
    CH_OFF, CH_STRAP, CH_INIT, CH_READY
  } ch_state_e;

  function automatic int timer_w(
    input int a,
    input int b,
    input int clks
  );
    int m;
    m = (a > b) ? a : b;
    return $clog2(m * clks + 1);
  endfunction

endpackage

// File: rtl/phy_power_sequencer_channel.sv
// One PHY strap/reset/init sequence with its own phase timer.
// Drops to CH_OFF whenever the rails or the enable go away.
module phy_seq_channel
  import phy_power_sequencer_pkg::*;
#(
  parameter int STRAP_CLKS = 4,
  parameter int INIT_CLKS  = 3,
  parameter int HOLD_CLKS  = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rails_on,
  input  logic en,
  input  logic restart,
  output logic phy_reset_n,
  output logic strap_oe,
  output logic ready
);

  localparam int TW = timer_w(STRAP_CLKS, INIT_CLKS, 1);
  localparam logic [TW-1:0] STRAP_LAST = TW'(STRAP_CLKS - 1);
  localparam logic [TW-1:0] INIT_LAST  = TW'(INIT_CLKS - 1);

  ch_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic rst_d, strap_d, ready_d;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    if (!en || !rails_on) begin
      state_d = CH_OFF;
    end else begin
      unique case (state_q)
        CH_OFF: state_d = CH_STRAP;
        CH_STRAP: begin
          if (!restart) begin
            if (timer_q == STRAP_LAST) state_d = CH_INIT;
            else timer_d = timer_q + TW'(1);
          end
        end
        CH_INIT: begin
          if (restart) state_d = CH_STRAP;
          else if (timer_q == INIT_LAST) state_d = CH_READY;
          else timer_d = timer_q + TW'(1);
        end
        CH_READY: if (restart) state_d = CH_STRAP;
        default: state_d = CH_OFF;
      endcase
    end
    rst_d   = (state_d == CH_INIT) || (state_d == CH_READY);
    // straps stay driven briefly after reset release for PHY latch hold
    strap_d = (state_d == CH_STRAP) ||
              ((state_d == CH_INIT) &&
               (32'(timer_d) < 32'(HOLD_CLKS)));
    ready_d = (state_d == CH_READY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CH_OFF;
      timer_q     <= '0;
      phy_reset_n <= 1'b0;
      strap_oe    <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phy_reset_n <= rst_d;
      strap_oe    <= strap_d;
      ready       <= ready_d;
    end
  end

endmodule

// File: rtl/phy_power_sequencer.sv
// Global VDDH/VDDL rail sequencer plus NUM_PHYS channel sequencers.
// Define PHY_SEQ_POWER_DOWN_EN to honour power_down.
module phy_power_sequencer
  import phy_power_sequencer_pkg::*;
#(
  parameter int NUM_PHYS        = 2,
  parameter int CLKS_PER_US     = 50,
  parameter int T_VDDH_US       = 1000000,
  parameter int T_VDDL_US       = 100000,
  parameter int T_STRAP_US      = 100000,
  parameter int T_INIT_US       = 100000,
  parameter int STRAP_HOLD_CLKS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_PHYS-1:0] phy_en,
  input  logic [NUM_PHYS-1:0] phy_restart,
  input  logic                power_down,
  output logic                vddh_en,
  output logic                vddl_en,
  output logic [NUM_PHYS-1:0] phy_reset_n,
  output logic [NUM_PHYS-1:0] strap_oe,
  output logic [NUM_PHYS-1:0] phy_ready,
  output logic                all_ready
);

  localparam int VDDH_CLKS  = T_VDDH_US * CLKS_PER_US;
  localparam int VDDL_CLKS  = T_VDDL_US * CLKS_PER_US;
  localparam int STRAP_CLKS = T_STRAP_US * CLKS_PER_US;
  localparam int INIT_CLKS  = T_INIT_US * CLKS_PER_US;
  localparam int TW = timer_w(T_VDDH_US, T_VDDL_US, CLKS_PER_US);
  localparam logic [TW-1:0] VDDH_LAST = TW'(VDDH_CLKS - 1);
  localparam logic [TW-1:0] VDDL_LAST = TW'(VDDL_CLKS - 1);

  g_state_e g_q, g_d;
  logic [TW-1:0] timer_q, timer_d;
  logic vddh_q, vddh_d;
  logic vddl_q, vddl_d;
  logic pd_accept;
  logic rails_on;

`ifdef PHY_SEQ_POWER_DOWN_EN
  assign pd_accept = power_down &&
                     ((g_q == G_VDDH) || (g_q == G_ON));
`else
  logic unused_power_down;
  assign unused_power_down = power_down;
  assign pd_accept = 1'b0;
`endif

  always_comb begin
    g_d     = g_q;
    timer_d = '0;
    vddh_d  = vddh_q;
    vddl_d  = vddl_q;
    unique case (g_q)
      G_OFF: begin
        if (timer_q == VDDH_LAST) begin
          g_d    = G_VDDH;
          vddh_d = 1'b1;
        end else timer_d = timer_q + TW'(1);
      end
      G_VDDH: begin
        if (timer_q == VDDL_LAST) begin
          g_d    = G_ON;
          vddl_d = 1'b1;
        end else timer_d = timer_q + TW'(1);
      end
      G_ON: g_d = G_ON;
`ifdef PHY_SEQ_POWER_DOWN_EN
      G_DOWN: begin
        if (timer_q == VDDL_LAST) begin
          g_d    = G_OFF;
          vddh_d = 1'b0;
        end else timer_d = timer_q + TW'(1);
      end
`endif
      default: g_d = G_OFF;
    endcase
`ifdef PHY_SEQ_POWER_DOWN_EN
    if (pd_accept) begin
      g_d     = G_DOWN;
      timer_d = '0;
      vddl_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g_q     <= G_OFF;
      timer_q <= '0;
      vddh_q  <= 1'b0;
      vddl_q  <= 1'b0;
    end else begin
      g_q     <= g_d;
      timer_q <= timer_d;
      vddh_q  <= vddh_d;
      vddl_q  <= vddl_d;
    end
  end

  // an accepted shutdown pulls channels off on the same edge as vddl
  assign rails_on = vddl_q & ~pd_accept;

  for (genvar i = 0; i < NUM_PHYS; i++) begin : g_ch
    phy_seq_channel #(
      .STRAP_CLKS(STRAP_CLKS),
      .INIT_CLKS (INIT_CLKS),
      .HOLD_CLKS (STRAP_HOLD_CLKS)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .rails_on   (rails_on),
      .en         (phy_en[i]),
      .restart    (phy_restart[i]),
      .phy_reset_n(phy_reset_n[i]),
      .strap_oe   (strap_oe[i]),
      .ready      (phy_ready[i])
    );
  end

  assign vddh_en   = vddh_q;
  assign vddl_en   = vddl_q;
  assign all_ready = vddh_q & vddl_q & (|phy_en) &
                     (&(phy_ready | ~phy_en));

endmodule

// File: tb/tb_phy_power_sequencer.sv
// Randomized and directed bench for phy_power_sequencer.
// Reference model works from phase start times, not FSM states.
module tb_phy_power_sequencer;

  localparam int TVH  = 10;
  localparam int TVL  = 5;
  localparam int TS   = 4;
  localparam int TI   = 3;
  localparam int HOLD = 2;

  logic       clock;
  logic       reset_n;
  logic [1:0] phy_en;
  logic [1:0] phy_restart;
  logic       power_down;
  logic       vddh_en;
  logic       vddl_en;
  logic [1:0] phy_reset_n;
  logic [1:0] strap_oe;
  logic [1:0] phy_ready;
  logic       all_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int m_t;
  int m_up_t0;
  int m_down_t;
  bit m_down;
  bit m_vddh;
  bit m_vddl;
  int m_start [2];

  phy_power_sequencer #(
    .NUM_PHYS       (2),
    .CLKS_PER_US    (1),
    .T_VDDH_US      (TVH),
    .T_VDDL_US      (TVL),
    .T_STRAP_US     (TS),
    .T_INIT_US      (TI),
    .STRAP_HOLD_CLKS(HOLD)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .phy_en     (phy_en),
    .phy_restart(phy_restart),
    .power_down (power_down),
    .vddh_en    (vddh_en),
    .vddl_en    (vddl_en),
    .phy_reset_n(phy_reset_n),
    .strap_oe   (strap_oe),
    .phy_ready  (phy_ready),
    .all_ready  (all_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] obs();
    return {vddh_en, vddl_en, phy_reset_n,
            strap_oe, phy_ready, all_ready};
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [1:0] rn, so, rd;
    logic ar;
    int e;
    rn = '0; so = '0; rd = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_start[i] >= 0) begin
        e = m_t - m_start[i];
        rn[i] = (e >= TS);
        so[i] = (e < TS + HOLD) && (e < TS + TI);
        rd[i] = (e >= TS + TI);
      end
    end
    ar = m_vddh && m_vddl && (|phy_en) && (&(rd | ~phy_en));
    return {m_vddh, m_vddl, rn, so, rd, ar};
  endfunction

  task automatic model_reset();
    m_t = 0; m_up_t0 = 0; m_down_t = 0;
    m_down = 0; m_vddh = 0; m_vddl = 0;
    m_start[0] = -1; m_start[1] = -1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic tick();
    bit pd_acc;
    bit rails;
    @(posedge clock);
    pd_acc = 1'b0;
`ifdef PHY_SEQ_POWER_DOWN_EN
    pd_acc = power_down && m_vddh && !m_down;
`endif
    rails = m_vddl && !pd_acc;
    m_t++;
    if (m_down && (m_t - m_down_t == TVL)) begin
      m_down = 0;
      m_up_t0 = m_t;
    end
    if (pd_acc) begin
      m_down = 1;
      m_down_t = m_t;
    end
    m_vddh = m_down || (m_t - m_up_t0 >= TVH);
    m_vddl = !m_down && (m_t - m_up_t0 >= TVH + TVL);
    for (int i = 0; i < 2; i++) begin
      if (!phy_en[i] || !rails) m_start[i] = -1;
      else if (m_start[i] < 0 || phy_restart[i]) m_start[i] = m_t;
    end
    #1;
  endtask

  task automatic test_reset();
    phy_en = 2'b00; phy_restart = 2'b00; power_down = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", obs(), 9'h000);
    end
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_power_up();
    logic [8:0] spot;
    bit use_spot;
    phy_en = 2'b11;
    apply_reset();
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pwrup_model t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
      use_spot = 1'b1;
      spot = '0;
      case (k)
        10: spot = 9'b10_00_00_00_0;
        15: spot = 9'b11_00_00_00_0;
        16: spot = 9'b11_00_11_00_0;
        20: spot = 9'b11_11_11_00_0;
        22: spot = 9'b11_11_00_00_0;
        23: spot = 9'b11_11_00_11_1;
        default: use_spot = 1'b0;
      endcase
      if (use_spot) begin
        n_checks++;
        if (obs() !== spot) begin
          n_fail++;
          $display("FAIL pwrup_spot t=%0d: got %b want %b",
                   k, obs(), spot);
        end
      end
    end
  endtask

  task automatic test_single_enable();
    phy_en = 2'b01;
    apply_reset();
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_model t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
      if (k == 16 || k == 23) begin
        n_checks++;
        if (obs() !== (k == 16 ? 9'b11_00_01_00_0
                                : 9'b11_01_00_01_1)) begin
          n_fail++;
          $display("FAIL single_spot t=%0d: got %b", k, obs());
        end
      end
    end
    phy_en = 2'b00;
    #1;
    n_checks++;
    if (all_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL all_ready_off: got %b want 0", all_ready);
    end
    tick();
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL single_disable: got %b want %b",
               obs(), exp_vec());
    end
  endtask

  task automatic test_restart();
    phy_en = 2'b11;
    apply_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k == 31) phy_restart = 2'b10;
      tick();
      phy_restart = 2'b00;
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL restart_model t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
      if (k == 31 || k == 35 || k == 38) begin
        n_checks++;
        if (obs() !== (k == 31 ? 9'b11_01_10_01_0 :
                       k == 35 ? 9'b11_11_10_01_0 :
                                 9'b11_11_00_11_1)) begin
          n_fail++;
          $display("FAIL restart_spot t=%0d: got %b", k, obs());
        end
      end
    end
  endtask

  task automatic test_en_priority();
    phy_en = 2'b10;
    phy_restart = 2'b01;
    tick();
    phy_restart = 2'b00;
    n_checks++;
    if (obs() !== 9'b11_10_00_10_1) begin
      n_fail++;
      $display("FAIL en_priority: got %b want %b",
               obs(), 9'b11_10_00_10_1);
    end
    phy_en = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reenable_model t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
      if (k == 7 || k == 8) begin
        n_checks++;
        if (phy_ready[0] !== (k == 8)) begin
          n_fail++;
          $display("FAIL reenable_ready k=%0d: got %b want %b",
                   k, phy_ready[0], k == 8);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    phy_en = 2'b11;
    apply_reset();
    repeat (21) tick();
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 9'h000) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs(), 9'h000);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_model t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
    end
    n_checks++;
    if (obs() !== 9'b11_11_00_11_1) begin
      n_fail++;
      $display("FAIL async_repeat: got %b want %b",
               obs(), 9'b11_11_00_11_1);
    end
  endtask

  task automatic test_power_down();
    logic [8:0] s41, s46, s56;
`ifdef PHY_SEQ_POWER_DOWN_EN
    s41 = 9'b10_00_00_00_0;
    s46 = 9'b00_00_00_00_0;
    s56 = 9'b10_00_00_00_0;
`else
    s41 = 9'b11_11_00_11_1;
    s46 = 9'b11_11_00_11_1;
    s56 = 9'b11_11_00_11_1;
`endif
    phy_en = 2'b11;
    apply_reset();
    for (int k = 1; k <= 60; k++) begin
      power_down = (k == 41);
      tick();
      power_down = 1'b0;
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pdown_model t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
      if (k == 41 || k == 46 || k == 56) begin
        n_checks++;
        if (obs() !== (k == 41 ? s41 : k == 46 ? s46 : s56)) begin
          n_fail++;
          $display("FAIL pdown_spot t=%0d: got %b", k, obs());
        end
      end
    end
  endtask

  task automatic test_random();
    phy_en = 2'($urandom_range(3, 0));
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(99, 0) < 3) phy_en[i] = ~phy_en[i];
        phy_restart[i] = ($urandom_range(99, 0) < 4);
      end
      power_down = ($urandom_range(99, 0) < 1);
      tick();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random t=%0d: got %b want %b",
                 m_t, obs(), exp_vec());
      end
    end
    phy_restart = 2'b00;
    power_down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_single_enable();
    test_restart();
    test_en_priority();
    test_async_reset();
    test_power_down();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
